// File: rtl/clock_div_gen.sv
// Multi-channel programmable clock divider.
// Each channel emits a 50%-duty divided clock with a half-period of
// (div_active + 1) CLOCK cycles, a one-cycle TICK on every rising half and a
// RUNNING flag. Enable and divide-ratio changes are only honoured at period
// boundaries, so every emitted half-period has its full length.

module clock_div_chan #(
  parameter int DIV_W = 8
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             enable,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             clk_out,
  output logic             tick,
  output logic             running
);

  // state | meaning
  // IDLE  | stopped, clk_out low, waiting for enable
  // HIGH  | first half of a period, clk_out high, enable ignored
  // LOW   | second half of a period, period boundary at its last cycle

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] count, count_nxt;
  logic [DIV_W-1:0] div_active, div_active_nxt;
  logic [DIV_W-1:0] div_pending, div_pending_nxt;
  logic             pending, pending_nxt;
  logic             clk_out_nxt;
  logic             tick_nxt;

  logic             half_done;
  logic [DIV_W-1:0] div_boundary;

  // A LOAD on the boundary edge itself beats an older pending value.
  assign div_boundary = load    ? div :
                        pending ? div_pending :
                                  div_active;

  assign half_done = (count == div_active);
  assign running   = (state != ST_IDLE);

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state       <= ST_IDLE;
      count       <= '0;
      div_active  <= '0;
      div_pending <= '0;
      pending     <= 1'b0;
      clk_out     <= 1'b0;
      tick        <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      div_active  <= div_active_nxt;
      div_pending <= div_pending_nxt;
      pending     <= pending_nxt;
      clk_out     <= clk_out_nxt;
      tick        <= tick_nxt;
    end
  end

  // Next-state, counter, ratio-update and output decode.
  always_comb begin
    state_nxt       = state;
    count_nxt       = count;
    div_active_nxt  = div_active;
    div_pending_nxt = div_pending;
    pending_nxt     = pending;
    clk_out_nxt     = clk_out;
    tick_nxt        = 1'b0;

    case (state)
      ST_IDLE: begin
        // Ratio updates in IDLE apply at once, whether or not we start now.
        div_active_nxt = div_boundary;
        pending_nxt    = 1'b0;
        count_nxt      = '0;
        clk_out_nxt    = 1'b0;
        if (enable) begin
          state_nxt   = ST_HIGH;
          clk_out_nxt = 1'b1;
          tick_nxt    = 1'b1;
        end
      end

      ST_HIGH: begin
        if (load) begin
          div_pending_nxt = div;
          pending_nxt     = 1'b1;
        end
        if (half_done) begin
          state_nxt   = ST_LOW;
          count_nxt   = '0;
          clk_out_nxt = 1'b0;
        end else begin
          count_nxt = count + 1'b1;
        end
      end

      ST_LOW: begin
        if (half_done) begin
          div_active_nxt = div_boundary;
          pending_nxt    = 1'b0;
          count_nxt      = '0;
          if (enable) begin
            state_nxt   = ST_HIGH;
            clk_out_nxt = 1'b1;
            tick_nxt    = 1'b1;
          end else begin
            state_nxt   = ST_IDLE;
            clk_out_nxt = 1'b0;
          end
        end else begin
          count_nxt = count + 1'b1;
          if (load) begin
            div_pending_nxt = div;
            pending_nxt     = 1'b1;
          end
        end
      end

      default: begin
        state_nxt   = ST_IDLE;
        count_nxt   = '0;
        clk_out_nxt = 1'b0;
      end
    endcase
  end

endmodule

module clock_div_gen #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic [NUM_CH-1:0]       ENABLE,
  input  logic [NUM_CH*DIV_W-1:0] DIV,
  input  logic [NUM_CH-1:0]       LOAD,
  output logic [NUM_CH-1:0]       CLK_OUT,
  output logic [NUM_CH-1:0]       TICK,
  output logic [NUM_CH-1:0]       RUNNING
);

  // Channels are fully independent; each owns its own slice of DIV.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    clock_div_chan #(
      .DIV_W (DIV_W)
    ) u_chan (
      .CLOCK   (CLOCK),
      .RESET   (RESET),
      .enable  (ENABLE[ch]),
      .load    (LOAD[ch]),
      .div     (DIV[ch*DIV_W +: DIV_W]),
      .clk_out (CLK_OUT[ch]),
      .tick    (TICK[ch]),
      .running (RUNNING[ch])
    );
  end

endmodule

// File: tb/tb_clock_div_gen.sv
// Directed bench for clock_div_gen with hand-computed waveforms.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.

module tb_clock_div_gen;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;

  logic                    CLOCK;
  logic                    RESET;
  logic [NUM_CH-1:0]       ENABLE;
  logic [NUM_CH*DIV_W-1:0] DIV;
  logic [NUM_CH-1:0]       LOAD;
  logic [NUM_CH-1:0]       CLK_OUT;
  logic [NUM_CH-1:0]       TICK;
  logic [NUM_CH-1:0]       RUNNING;

  int n_chk;
  int n_fail;

  clock_div_gen #(
    .NUM_CH (NUM_CH),
    .DIV_W  (DIV_W)
  ) dut (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .ENABLE  (ENABLE),
    .DIV     (DIV),
    .LOAD    (LOAD),
    .CLK_OUT (CLK_OUT),
    .TICK    (TICK),
    .RUNNING (RUNNING)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic set_div(input int ch, input logic [DIV_W-1:0] val);
    DIV[ch*DIV_W +: DIV_W] = val;
  endtask

  // Expected waveforms for tests 4 and 5 (index = cycles since first rise).
  logic [11:0] t4_clk;
  logic [11:0] t4_tick;
  logic [15:0] t5_clk;
  logic [15:0] t5_tick;

  initial begin
    int n;
    n_chk  = 0;
    n_fail = 0;
    t4_clk  = 12'b1100_1100_0111;  // bit i = cycle i: 1,1,1,0,0,0,1,1,0,0,1,1
    t4_tick = 12'b0100_0100_0001;  // ticks at 0, 6, 10
    t5_clk  = 16'b1100_0001_1111_0011; // 1,1,0,0,1,1,1,1,1,0,0,0,0,0,1,1
    t5_tick = 16'b0100_0000_0001_0001; // ticks at 0, 4, 14

    RESET  = 1'b1;
    ENABLE = '0;
    LOAD   = '0;
    DIV    = '0;
    #1;
    chk("reset_clk",  CLK_OUT, 0);
    chk("reset_tick", TICK,    0);
    chk("reset_run",  RUNNING, 0);
    step();
    step();
    RESET = 1'b0;
    step();
    chk("idle_run", RUNNING, 0);

    // Test 1: channel 0, div_active = 0 -> CLOCK/2.
    ENABLE = 4'b0001;
    step();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t1_clk[%0d]",  i), CLK_OUT[0], (i % 2 == 0));
      chk($sformatf("t1_tick[%0d]", i), TICK[0],    (i % 2 == 0));
      chk($sformatf("t1_run[%0d]",  i), RUNNING[0], 1);
      step();
    end

    // Test 2: LOAD 3 on channel 1 while idle, then enable; DIV changes without LOAD ignored.
    set_div(1, 8'd3);
    LOAD = 4'b0010;
    step();
    LOAD = '0;
    DIV  = '0;
    chk("t2_idle_run", RUNNING[1], 0);
    ENABLE = 4'b0011;
    step();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t2_clk[%0d]",  i), CLK_OUT[1], ((i % 8) < 4));
      chk($sformatf("t2_tick[%0d]", i), TICK[1],    ((i % 8) == 0));
      step();
    end

    // Test 3: drop enable one cycle into the high half (now at cycle 16 = rise).
    chk("t3_rise_clk",  CLK_OUT[1], 1);
    chk("t3_rise_tick", TICK[1],    1);
    ENABLE = 4'b0001;
    step();
    for (int j = 1; j <= 12; j++) begin
      chk($sformatf("t3_clk[%0d]",  j), CLK_OUT[1], (j <= 3));
      chk($sformatf("t3_run[%0d]",  j), RUNNING[1], (j <= 7));
      chk($sformatf("t3_tick[%0d]", j), TICK[1],    0);
      step();
    end

    // Test 4: channel 2 at DIV=2, LOAD 5 mid-high then LOAD 1 mid-low.
    set_div(2, 8'd2);
    LOAD = 4'b0100;
    step();
    LOAD   = '0;
    ENABLE = 4'b0101;
    step();
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("t4_clk[%0d]",  i), CLK_OUT[2], t4_clk[i]);
      chk($sformatf("t4_tick[%0d]", i), TICK[2],    t4_tick[i]);
      LOAD = '0;
      if (i == 0) begin
        set_div(2, 8'd5);
        LOAD = 4'b0100;
      end else if (i == 3) begin
        set_div(2, 8'd1);
        LOAD = 4'b0100;
      end
      step();
    end
    LOAD = '0;

    // Test 5: channel 3 at DIV=1, LOAD 4 exactly on the period boundary edge.
    set_div(3, 8'd1);
    LOAD = 4'b1000;
    step();
    LOAD   = '0;
    ENABLE = 4'b1101;
    step();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t5_clk[%0d]",  i), CLK_OUT[3], t5_clk[i]);
      chk($sformatf("t5_tick[%0d]", i), TICK[3],    t5_tick[i]);
      LOAD = '0;
      if (i == 3) begin
        set_div(3, 8'd4);
        LOAD = 4'b1000;
      end
      if (i < 15) step();
    end
    LOAD = '0;

    // Test 6: reset mid-high (channel 3 is in its high half), then aligned restart.
    chk("t6_pre_clk3", CLK_OUT[3], 1);
    RESET = 1'b1;
    #1;
    chk("t6_rst_clk",  CLK_OUT, 0);
    chk("t6_rst_tick", TICK,    0);
    chk("t6_rst_run",  RUNNING, 0);
    ENABLE = 4'b1111;
    DIV    = {4{8'd1}};
    LOAD   = 4'b1111;
    step();
    step();
    chk("t6_rst2_clk", CLK_OUT, 0);
    chk("t6_rst2_run", RUNNING, 0);
    RESET = 1'b0;
    step();
    LOAD = '0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("t6_clk[%0d]",  i), CLK_OUT, ((i % 4) < 2) ? 4'hF : 4'h0);
      chk($sformatf("t6_tick[%0d]", i), TICK,    ((i % 4) == 0) ? 4'hF : 4'h0);
      chk($sformatf("t6_run[%0d]",  i), RUNNING, 4'hF);
      step();
    end

    // Test 7: maximum ratio DIV=255 -> 256 high, 256 low.
    RESET = 1'b1;
    #1;
    ENABLE = 4'b0001;
    DIV    = '0;
    set_div(0, 8'hFF);
    LOAD   = 4'b0001;
    step();
    RESET = 1'b0;
    step();
    LOAD = '0;
    chk("t7_rise_tick", TICK[0], 1);
    n = 0;
    while (CLK_OUT[0] === 1'b1 && n < 1000) begin
      n++;
      step();
    end
    chk("t7_high_len", n, 256);
    n = 0;
    while (CLK_OUT[0] === 1'b0 && n < 1000) begin
      n++;
      step();
    end
    chk("t7_low_len", n, 256);
    chk("t7_tick2", TICK[0], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
